// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone slave-port arbiter: grant held for a whole CYC, one idle turnaround cycle between tenures.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr #(
    parameter int N_MASTERS       = 2,
    parameter int N_MASTERID_BITS = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MASTERS-1:0]       m_cyc,
    input  logic [N_MASTERS-1:0]       m_stb,
    input  logic                       s_ack,
    input  logic                       s_err,
    output logic [N_MASTERS-1:0]       gnt,
    output logic [N_MASTERID_BITS-1:0] gnt_id,
    output logic                       gnt_valid,
    output logic                       to_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [N_MASTERS-1:0]       ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [N_MASTERID_BITS-1:0] LAST_ID  = N_MASTERID_BITS'(N_MASTERS - 1);

    state_t                     state_q, state_d;
    logic [N_MASTERS-1:0]       gnt_q, gnt_d;
    logic [N_MASTERID_BITS-1:0] gntId_q, gntId_d;
    logic                       gntValid_q, gntValid_d;
    logic [N_MASTERID_BITS-1:0] ptr_q, ptr_d;

    logic [N_MASTERID_BITS-1:0] winner;
    logic                       winnerFound;
    logic                       grantedCyc;

    assign grantedCyc = |(m_cyc & gnt_q);

    // Two descending scans: the last hit is the lowest index, so the first scan
    // finds the lowest requester at or above ptr, the second wraps below ptr.
    always_comb begin
        winner      = '0;
        winnerFound = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_cyc[i] && (i >= int'(ptr_q))) begin
                winner      = N_MASTERID_BITS'(i);
                winnerFound = 1'b1;
            end
        end
        if (!winnerFound) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (m_cyc[i] && (i < int'(ptr_q))) begin
                    winner      = N_MASTERID_BITS'(i);
                    winnerFound = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gntId_d    = gntId_q;
        gntValid_d = gntValid_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    state_d    = GRANT;
                    gnt_d      = ONE_HOT0 << winner;
                    gntId_d    = winner;
                    gntValid_d = 1'b1;
                    ptr_d      = (winner == LAST_ID) ? '0 : winner + N_MASTERID_BITS'(1);
                end
            end
            GRANT: begin
                if (!grantedCyc) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    gntValid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gntValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gntId_q    <= '0;
            gntValid_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gntId_q    <= gntId_d;
            gntValid_q <= gntValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gntId_q;
    assign gnt_valid = gntValid_q;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wdCount_q, wdCount_d;
    logic        toErr_q, toErr_d;
    logic        grantedStb;
    logic        stall;

    // Counting only while the owner still holds CYC keeps to_err out of IDLE.
    assign grantedStb = |(m_stb & gnt_q);
    assign stall      = (state_q == GRANT) && grantedCyc && grantedStb && !s_ack && !s_err;

    always_comb begin
        wdCount_d = '0;
        toErr_d   = 1'b0;
        if (stall) begin
            if (wdCount_q == 16'(TIMEOUT_CYCLES - 1)) begin
                toErr_d = 1'b1;
            end else begin
                wdCount_d = wdCount_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdCount_q <= '0;
            toErr_q   <= 1'b0;
        end else begin
            wdCount_q <= wdCount_d;
            toErr_q   <= toErr_d;
        end
    end

    assign to_err = toErr_q;
`else
    logic unusedWatchdogInputs;
    assign unusedWatchdogInputs = ^{m_stb, s_ack, s_err, 16'(TIMEOUT_CYCLES)};
    assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Scoreboard bench for wb_arbiter_rr: directed vectors push expected outputs, a monitor pops and compares.
// Instances for N_MASTERS = 2 (watchdog timeout 4), 3 and 4 share clock and reset.
module tb_wb_arbiter_rr;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sAck = 1'b0;
    logic       sErr = 1'b0;

    logic [1:0] cyc2 = '0, stb2 = '0, gnt2;
    logic [0:0] id2;
    logic       valid2, toErr2;
    logic [2:0] cyc3 = '0, stb3 = '0, gnt3;
    logic [1:0] id3;
    logic       valid3, toErr3;
    logic [3:0] cyc4 = '0, stb4 = '0, gnt4;
    logic [1:0] id4;
    logic       valid4, toErr4;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.N_MASTERS(2), .TIMEOUT_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .m_cyc(cyc2), .m_stb(stb2), .s_ack(sAck), .s_err(sErr),
        .gnt(gnt2), .gnt_id(id2), .gnt_valid(valid2), .to_err(toErr2));

    wb_arbiter_rr #(.N_MASTERS(3)) dut3 (
        .clk(clk), .rst(rst), .m_cyc(cyc3), .m_stb(stb3), .s_ack(sAck), .s_err(sErr),
        .gnt(gnt3), .gnt_id(id3), .gnt_valid(valid3), .to_err(toErr3));

    wb_arbiter_rr #(.N_MASTERS(4)) dut4 (
        .clk(clk), .rst(rst), .m_cyc(cyc4), .m_stb(stb4), .s_ack(sAck), .s_err(sErr),
        .gnt(gnt4), .gnt_id(id4), .gnt_valid(valid4), .to_err(toErr4));

    typedef struct {
        int         idx;
        int         sel;
        logic [3:0] gnt;
        logic [1:0] id;
        bit         chkId;
        logic       valid;
        logic       toErr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    int   vecIdx = 0;

    task automatic compareOne(input int idx, input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL v%0d %s: got %b required %b", idx, name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] aGnt;
        logic [1:0] aId;
        logic       aValid, aToErr;
        aGnt = '0; aId = '0; aValid = 1'b0; aToErr = 1'b0;
        case (e.sel)
            2: begin aGnt = {2'b00, gnt2}; aId = {1'b0, id2}; aValid = valid2; aToErr = toErr2; end
            3: begin aGnt = {1'b0, gnt3};  aId = id3;         aValid = valid3; aToErr = toErr3; end
            default: begin aGnt = gnt4;    aId = id4;         aValid = valid4; aToErr = toErr4; end
        endcase
        compareOne(e.idx, "gnt", aGnt, e.gnt);
        compareOne(e.idx, "gnt_valid", {3'b0, aValid}, {3'b0, e.valid});
        compareOne(e.idx, "to_err", {3'b0, aToErr}, {3'b0, e.toErr});
        if (e.chkId) compareOne(e.idx, "gnt_id", {2'b0, aId}, {2'b0, e.id});
    endtask

    // Monitor: registered outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    task automatic applyStimulus(input int sel, input logic r, input logic [3:0] cyc, input logic [3:0] stb,
                                 input logic ack, input logic [3:0] eGnt, input logic [1:0] eId,
                                 input logic eValid, input logic eToErr);
        exp_t e;
        @(negedge clk);
        rst  = r;
        sAck = ack;
        cyc2 = (sel == 2) ? cyc[1:0] : 2'b00;
        stb2 = (sel == 2) ? stb[1:0] : 2'b00;
        cyc3 = (sel == 3) ? cyc[2:0] : 3'b000;
        stb3 = (sel == 3) ? stb[2:0] : 3'b000;
        cyc4 = (sel == 4) ? cyc : 4'b0000;
        stb4 = (sel == 4) ? stb : 4'b0000;
        e.idx   = vecIdx;
        e.sel   = sel;
        e.gnt   = eGnt;
        e.id    = eId;
        e.chkId = eValid | r;
        e.valid = eValid;
        e.toErr = eToErr;
        expQ.push_back(e);
        vecIdx++;
    endtask

    int rrOrder[5] = '{0, 1, 2, 3, 0};

    initial begin
        int waitCycles;
        $display("[TB] start");
        // Reset and single request from master 1
        applyStimulus(2, 1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        repeat (3) applyStimulus(2, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // Burst hold: master 0 keeps CYC for 8 beats while master 1 waits
        applyStimulus(2, 0, 4'b0001, 4'b0001, 1, 4'b0001, 2'd0, 1, 0);
        repeat (8) applyStimulus(2, 0, 4'b0011, 4'b0011, 1, 4'b0001, 2'd0, 1, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // Reset mid-grant clears grant and pointer
        applyStimulus(2, 0, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 0);
        applyStimulus(2, 1, 4'b0001, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 1, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 1, 4'b0010, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(2, 0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 1, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // Request dropped in the cycle it was sampled still gets one grant cycle
        applyStimulus(2, 0, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // Watchdog: master 1 stalls with timeout 4, then an ACK on stall cycle 3
        applyStimulus(2, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        repeat (2) begin
            repeat (3) applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
            applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, WD);
        end
        applyStimulus(2, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0010, 1, 4'b0010, 2'd1, 1, 0);
        repeat (3) applyStimulus(2, 0, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(2, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // Round-robin with four masters: each holds 3 cycles, drops for one, re-raises
        for (int i = 0; i < 5; i++) begin
            int m;
            m = rrOrder[i];
            repeat (3) applyStimulus(4, 0, 4'hF, 4'h0, 0, 4'(1 << m), 2'(m), 1, 0);
            applyStimulus(4, 0, 4'hF & ~4'(1 << m), 4'h0, 0, 4'b0000, 2'd0, 0, 0);
        end

        // Three masters: pointer wraps from 2 to 0
        applyStimulus(3, 0, 4'b0100, 4'b0000, 0, 4'b0100, 2'd2, 1, 0);
        applyStimulus(3, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(3, 0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 1, 0);
        applyStimulus(3, 0, 4'b0010, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(3, 0, 4'b0011, 4'b0000, 0, 4'b0010, 2'd1, 1, 0);
        applyStimulus(3, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(3, 0, 4'b0111, 4'b0000, 0, 4'b0100, 2'd2, 1, 0);
        applyStimulus(3, 0, 4'b0011, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        applyStimulus(3, 0, 4'b0111, 4'b0000, 0, 4'b0001, 2'd0, 1, 0);
        applyStimulus(3, 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // Drain the scoreboard with a bounded wait
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            #2;
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending entries required 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
